// File: rtl/axi_single_master.sv
// Single-outstanding AXI4 master: turns a simple req/gnt core interface into one
// single-beat AXI4 read or write, with a registered one-cycle completion pulse.
module axi_single_master #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH/8,
  parameter int unsigned MASTER_ID      = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [AXI_DATA_WIDTH-1:0] wdata_i,
  input  logic [AXI_STRB_WIDTH-1:0] be_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic                      master_aw_valid,
  input  logic                      master_aw_ready,
  output logic [AXI_ADDR_WIDTH-1:0] master_aw_addr,
  output logic [AXI_ID_WIDTH-1:0]   master_aw_id,
  output logic [AXI_USER_WIDTH-1:0] master_aw_user,
  output logic [7:0]                master_aw_len,
  output logic [2:0]                master_aw_size,
  output logic [1:0]                master_aw_burst,
  output logic [2:0]                master_aw_prot,
  output logic [3:0]                master_aw_region,
  output logic                      master_aw_lock,
  output logic [3:0]                master_aw_cache,
  output logic [3:0]                master_aw_qos,
  output logic                      master_w_valid,
  input  logic                      master_w_ready,
  output logic [AXI_DATA_WIDTH-1:0] master_w_data,
  output logic [AXI_STRB_WIDTH-1:0] master_w_strb,
  output logic [AXI_USER_WIDTH-1:0] master_w_user,
  output logic                      master_w_last,
  input  logic                      master_b_valid,
  output logic                      master_b_ready,
  input  logic [1:0]                master_b_resp,
  input  logic [AXI_ID_WIDTH-1:0]   master_b_id,
  input  logic [AXI_USER_WIDTH-1:0] master_b_user,
  output logic                      master_ar_valid,
  input  logic                      master_ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0] master_ar_addr,
  output logic [AXI_ID_WIDTH-1:0]   master_ar_id,
  output logic [AXI_USER_WIDTH-1:0] master_ar_user,
  output logic [7:0]                master_ar_len,
  output logic [2:0]                master_ar_size,
  output logic [1:0]                master_ar_burst,
  output logic [2:0]                master_ar_prot,
  output logic [3:0]                master_ar_region,
  output logic                      master_ar_lock,
  output logic [3:0]                master_ar_cache,
  output logic [3:0]                master_ar_qos,
  input  logic                      master_r_valid,
  output logic                      master_r_ready,
  input  logic [AXI_DATA_WIDTH-1:0] master_r_data,
  input  logic [1:0]                master_r_resp,
  input  logic                      master_r_last,
  input  logic [AXI_ID_WIDTH-1:0]   master_r_id,
  input  logic [AXI_USER_WIDTH-1:0] master_r_user
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA} state_e;

  localparam logic [2:0] AXSIZE = 3'($clog2(AXI_STRB_WIDTH));

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXI_STRB_WIDTH-1:0] be_q, be_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                      rvalid_q, rvalid_d, err_q, err_d;
  logic                      aw_hs, w_hs;

  // Handshake signals derive from state only, never from the matching ready.
  assign gnt_o           = (state_q == IDLE) & req_i;
  assign master_aw_valid = (state_q == WRITE) & ~aw_done_q;
  assign master_w_valid  = (state_q == WRITE) & ~w_done_q;
  assign master_b_ready  = (state_q == WRESP);
  assign master_ar_valid = (state_q == READ);
  assign master_r_ready  = (state_q == RDATA);
  assign aw_hs           = master_aw_valid & master_aw_ready;
  assign w_hs            = master_w_valid & master_w_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: if (req_i) begin
        addr_d  = addr_i;
        wdata_d = wdata_i;
        be_d    = be_i;
        state_d = we_i ? WRITE : READ;
      end
      WRITE: begin
        // AW and W may complete in either order; move on once both have.
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WRESP;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      WRESP: if (master_b_valid) begin
        rvalid_d = 1'b1;
        err_d    = (master_b_resp != 2'b00);
        state_d  = IDLE;
      end
      READ: if (master_ar_ready) state_d = RDATA;
      RDATA: if (master_r_valid) begin
        rdata_d  = master_r_data;
        rvalid_d = 1'b1;
        err_d    = (master_r_resp != 2'b00);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

  assign master_aw_addr   = addr_q;
  assign master_aw_id     = AXI_ID_WIDTH'(MASTER_ID);
  assign master_aw_user   = '0;
  assign master_aw_len    = 8'd0;
  assign master_aw_size   = AXSIZE;
  assign master_aw_burst  = 2'b01;
  assign master_aw_prot   = 3'b000;
  assign master_aw_region = 4'd0;
  assign master_aw_lock   = 1'b0;
  assign master_aw_cache  = 4'b0000;
  assign master_aw_qos    = 4'd0;

  assign master_w_data    = wdata_q;
  assign master_w_strb    = be_q;
  assign master_w_user    = '0;
  assign master_w_last    = 1'b1;

  assign master_ar_addr   = addr_q;
  assign master_ar_id     = AXI_ID_WIDTH'(MASTER_ID);
  assign master_ar_user   = '0;
  assign master_ar_len    = 8'd0;
  assign master_ar_size   = AXSIZE;
  assign master_ar_burst  = 2'b01;
  assign master_ar_prot   = 3'b000;
  assign master_ar_region = 4'd0;
  assign master_ar_lock   = 1'b0;
  assign master_ar_cache  = 4'b0000;
  assign master_ar_qos    = 4'd0;

  // Response IDs, user bits and r_last carry nothing for a single-beat, single-ID master.
  logic unused_inputs;
  assign unused_inputs = ^{master_b_id, master_b_user, master_r_last, master_r_id, master_r_user};

endmodule

// File: tb/tb_axi_single_master.sv
// Bench for axi_single_master: reactive AXI slave with programmable delays, a
// cycle-timing model of the expected behaviour, and directed transactions.
module tb_axi_single_master;
  logic        clk_i = 1'b0;
  logic        rst_ni, req_i, we_i;
  logic [31:0] addr_i;
  logic [63:0] wdata_i;
  logic [7:0]  be_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [63:0] rdata_o;
  logic        master_aw_valid, master_aw_ready, master_aw_lock;
  logic [31:0] master_aw_addr;
  logic [9:0]  master_aw_id;
  logic [5:0]  master_aw_user;
  logic [7:0]  master_aw_len;
  logic [2:0]  master_aw_size, master_aw_prot;
  logic [1:0]  master_aw_burst;
  logic [3:0]  master_aw_region, master_aw_cache, master_aw_qos;
  logic        master_w_valid, master_w_ready, master_w_last;
  logic [63:0] master_w_data;
  logic [7:0]  master_w_strb;
  logic [5:0]  master_w_user;
  logic        master_b_valid, master_b_ready;
  logic [1:0]  master_b_resp;
  logic [9:0]  master_b_id;
  logic [5:0]  master_b_user;
  logic        master_ar_valid, master_ar_ready, master_ar_lock;
  logic [31:0] master_ar_addr;
  logic [9:0]  master_ar_id;
  logic [5:0]  master_ar_user;
  logic [7:0]  master_ar_len;
  logic [2:0]  master_ar_size, master_ar_prot;
  logic [1:0]  master_ar_burst;
  logic [3:0]  master_ar_region, master_ar_cache, master_ar_qos;
  logic        master_r_valid, master_r_ready, master_r_last;
  logic [63:0] master_r_data;
  logic [1:0]  master_r_resp;
  logic [9:0]  master_r_id;
  logic [5:0]  master_r_user;

  axi_single_master dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o),
    .master_aw_valid(master_aw_valid), .master_aw_ready(master_aw_ready),
    .master_aw_addr(master_aw_addr), .master_aw_id(master_aw_id),
    .master_aw_user(master_aw_user), .master_aw_len(master_aw_len),
    .master_aw_size(master_aw_size), .master_aw_burst(master_aw_burst),
    .master_aw_prot(master_aw_prot), .master_aw_region(master_aw_region),
    .master_aw_lock(master_aw_lock), .master_aw_cache(master_aw_cache),
    .master_aw_qos(master_aw_qos),
    .master_w_valid(master_w_valid), .master_w_ready(master_w_ready),
    .master_w_data(master_w_data), .master_w_strb(master_w_strb),
    .master_w_user(master_w_user), .master_w_last(master_w_last),
    .master_b_valid(master_b_valid), .master_b_ready(master_b_ready),
    .master_b_resp(master_b_resp), .master_b_id(master_b_id), .master_b_user(master_b_user),
    .master_ar_valid(master_ar_valid), .master_ar_ready(master_ar_ready),
    .master_ar_addr(master_ar_addr), .master_ar_id(master_ar_id),
    .master_ar_user(master_ar_user), .master_ar_len(master_ar_len),
    .master_ar_size(master_ar_size), .master_ar_burst(master_ar_burst),
    .master_ar_prot(master_ar_prot), .master_ar_region(master_ar_region),
    .master_ar_lock(master_ar_lock), .master_ar_cache(master_ar_cache),
    .master_ar_qos(master_ar_qos),
    .master_r_valid(master_r_valid), .master_r_ready(master_r_ready),
    .master_r_data(master_r_data), .master_r_resp(master_r_resp),
    .master_r_last(master_r_last), .master_r_id(master_r_id), .master_r_user(master_r_user)
  );

  initial forever #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  // Slave timing knobs: cycles of valid before ready (AW/W/AR), cycles before B/R valid.
  int w_da = 0, w_dw = 0, w_db = 0, r_da = 0, r_dr = 0;
  logic [1:0]  w_resp = 2'b00, r_resp = 2'b00;
  logic [63:0] r_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reactive slave, updated just after each rising edge.
  initial begin
    int aw_c, w_c, ar_c, b_c, r_c;
    bit aw_g, w_g, b_arm, r_arm;
    aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
    aw_g = 0; w_g = 0; b_arm = 0; r_arm = 0;
    master_aw_ready = 0; master_w_ready = 0; master_ar_ready = 0;
    master_b_valid = 0; master_b_resp = 0; master_b_id = 10'h3; master_b_user = 6'h1;
    master_r_valid = 0; master_r_data = 0; master_r_resp = 0;
    master_r_last = 0; master_r_id = 10'h5; master_r_user = 6'h2;
    forever begin
      @(posedge clk_i); #1;
      if (!rst_ni) begin
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        aw_g = 0; w_g = 0; b_arm = 0; r_arm = 0;
        master_aw_ready = 0; master_w_ready = 0; master_ar_ready = 0;
        master_b_valid = 0; master_r_valid = 0;
        continue;
      end
      master_b_valid  = b_arm && (b_c >= w_db);
      master_b_resp   = w_resp;
      master_r_valid  = r_arm && (r_c >= r_dr);
      master_r_data   = r_data;
      master_r_resp   = r_resp;
      master_aw_ready = (aw_c >= w_da);
      master_w_ready  = (w_c >= w_dw);
      master_ar_ready = (ar_c >= r_da);
      if (master_b_valid && master_b_ready) b_arm = 0; else if (b_arm) b_c++;
      if (master_r_valid && master_r_ready) r_arm = 0; else if (r_arm) r_c++;
      if (master_aw_valid) begin
        if (master_aw_ready) begin aw_g = 1; aw_c = 0; end else aw_c++;
      end
      if (master_w_valid) begin
        if (master_w_ready) begin w_g = 1; w_c = 0; end else w_c++;
      end
      if (aw_g && w_g) begin aw_g = 0; w_g = 0; b_arm = 1; b_c = 0; end
      if (master_ar_valid) begin
        if (master_ar_ready) begin r_arm = 1; r_c = 0; ar_c = 0; end else ar_c++;
      end
    end
  end

  // Timing model: after a grant at cycle g, address valid spans g+1..g+1+delay,
  // the response ready window follows, and completion lands 3+delays after g.
  int          cyc = 0, t_g = 0, t_da = 0, t_dw = 0, t_dl = 0;
  bit          t_act = 0, t_we = 0;
  logic [31:0] t_addr = '0;
  logic [63:0] t_wdata = '0, t_rdata = '0, m_rdata = '0;
  logic [7:0]  t_be = '0;
  logic [1:0]  t_resp = '0;

  initial begin
    int off, mx, fin;
    bit busy, e_gnt, e_aw, e_w, e_b, e_ar, e_r, e_rv;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        chk("rst_gnt", gnt_o, req_i);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_handshakes", {master_aw_valid, master_w_valid, master_b_ready,
                               master_ar_valid, master_r_ready}, 0);
        t_act = 0; m_rdata = '0;
      end else begin
        off   = cyc - t_g;
        mx    = (t_we && t_dw > t_da) ? t_dw : t_da;
        fin   = 3 + mx + t_dl;
        busy  = t_act && off < fin;
        e_gnt = req_i && !busy;
        e_aw  = t_act && t_we && off >= 1 && off <= 1 + t_da;
        e_w   = t_act && t_we && off >= 1 && off <= 1 + t_dw;
        e_b   = t_act && t_we && off >= 2 + mx && off <= 2 + mx + t_dl;
        e_ar  = t_act && !t_we && off >= 1 && off <= 1 + t_da;
        e_r   = t_act && !t_we && off >= 2 + mx && off <= 2 + mx + t_dl;
        e_rv  = t_act && off == fin;
        if (e_rv && !t_we) m_rdata = t_rdata;
        chk("gnt", gnt_o, e_gnt);
        chk("aw_valid", master_aw_valid, e_aw);
        chk("w_valid", master_w_valid, e_w);
        chk("b_ready", master_b_ready, e_b);
        chk("ar_valid", master_ar_valid, e_ar);
        chk("r_ready", master_r_ready, e_r);
        chk("rvalid", rvalid_o, e_rv);
        chk("rdata", rdata_o, m_rdata);
        if (e_rv) chk("err", err_o, t_resp != 2'b00);
        if (e_aw) begin
          chk("aw_addr", master_aw_addr, t_addr);
          chk("aw_fixed", {master_aw_len, master_aw_size, master_aw_burst, master_aw_prot,
                           master_aw_region, master_aw_lock, master_aw_cache, master_aw_qos,
                           master_aw_user, master_aw_id},
                          {8'd0, 3'd3, 2'b01, 3'd0, 4'd0, 1'b0, 4'd0, 4'd0, 6'd0, 10'd0});
        end
        if (e_w) begin
          chk("w_data", master_w_data, t_wdata);
          chk("w_strb_last_user", {master_w_strb, master_w_last, master_w_user},
                                  {t_be, 1'b1, 6'd0});
        end
        if (e_ar) begin
          chk("ar_addr", master_ar_addr, t_addr);
          chk("ar_fixed", {master_ar_len, master_ar_size, master_ar_burst, master_ar_prot,
                           master_ar_region, master_ar_lock, master_ar_cache, master_ar_qos,
                           master_ar_user, master_ar_id},
                          {8'd0, 3'd3, 2'b01, 3'd0, 4'd0, 1'b0, 4'd0, 4'd0, 6'd0, 10'd0});
        end
        if (e_rv) t_act = 0;
        if (e_gnt) begin
          t_act = 1; t_g = cyc; t_we = we_i;
          t_addr = addr_i; t_wdata = wdata_i; t_be = be_i;
          if (we_i) begin
            t_da = w_da; t_dw = w_dw; t_dl = w_db; t_resp = w_resp;
          end else begin
            t_da = r_da; t_dw = 0; t_dl = r_dr; t_resp = r_resp; t_rdata = r_data;
          end
        end
      end
      cyc++;
    end
  end

  // One request; returns at the negedge of the completion cycle.
  task automatic txn(input bit we, input logic [31:0] a, input logic [63:0] d,
                     input logic [7:0] be, input int lat, input string nm);
    int k;
    k = 0;
    @(posedge clk_i); #1;
    req_i = 1; we_i = we; addr_i = a; wdata_i = d; be_i = be;
    @(negedge clk_i);
    chk({nm, "_gnt"}, gnt_o, 1);
    @(posedge clk_i); #1;
    req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; be_i = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_i);
      if (rvalid_o) begin k = i; break; end
    end
    chk({nm, "_latency"}, k, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst_ni = 0; req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; be_i = '0;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1;

    txn(1, 32'h1000, 64'hDEADBEEF_CAFEF00D, 8'hFF, 3, "wr_zero");
    chk("wr_zero_err", err_o, 0);
    chk("wr_zero_rdata", rdata_o, 0);

    w_da = 4;
    txn(1, 32'h1040, 64'h1122334455667788, 8'hF0, 7, "wr_awdly");
    chk("wr_awdly_err", err_o, 0);

    w_da = 1; w_dw = 3; w_db = 2; w_resp = 2'b10;
    txn(1, 32'h2008, 64'h5555AAAA5555AAAA, 8'h0F, 8, "wr_slverr");
    chk("wr_slverr_err", err_o, 1);

    r_resp = 2'b10; r_data = 64'h0123_4567_89AB_CDEF;
    txn(0, 32'h3000, '0, '0, 3, "rd_slverr");
    chk("rd_slverr_rdata", rdata_o, 64'h0123456789ABCDEF);
    chk("rd_slverr_err", err_o, 1);
    @(negedge clk_i);
    chk("rd_single_pulse", rvalid_o, 0);

    r_da = 2; r_dr = 3; r_resp = 2'b00; r_data = 64'hFEDC_BA98_7654_3210;
    txn(0, 32'h3100, '0, '0, 8, "rd_dly");
    chk("rd_dly_rdata", rdata_o, 64'hFEDCBA9876543210);
    chk("rd_dly_err", err_o, 0);

    w_da = 0; w_dw = 2; w_db = 0; w_resp = 2'b00;
    txn(1, 32'h4000, 64'h0F0F0F0F0F0F0F0F, 8'h3C, 5, "wr_keep");
    chk("wr_keep_rdata", rdata_o, 64'hFEDCBA9876543210);

    // req_i held high: read, then write granted on IDLE re-entry.
    w_dw = 0; r_da = 0; r_dr = 0; r_data = 64'hA5A5_0000_FFFF_1234;
    @(posedge clk_i); #1;
    req_i = 1; we_i = 0; addr_i = 32'h5000;
    @(negedge clk_i);
    chk("b2b_gnt_rd", gnt_o, 1);
    @(posedge clk_i); #1;
    we_i = 1; addr_i = 32'h6000; wdata_i = 64'hCAFE_0000_BEEF_0001; be_i = 8'hFF;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i);
      if (gnt_o) begin k = i; break; end
    end
    chk("b2b_regrant_gap", k, 3);
    chk("b2b_rd_done", rvalid_o, 1);
    chk("b2b_rd_rdata", rdata_o, 64'hA5A50000FFFF1234);
    @(posedge clk_i); #1;
    req_i = 0; we_i = 0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i);
      if (rvalid_o) begin k = i; break; end
    end
    chk("b2b_wr_latency", k, 3);
    chk("b2b_wr_rdata", rdata_o, 64'hA5A50000FFFF1234);

    // Reset while in WRESP with b_valid presented: transaction is dropped.
    @(posedge clk_i); #1;
    req_i = 1; we_i = 1; addr_i = 32'h7000; wdata_i = 64'h7777; be_i = 8'h01;
    @(negedge clk_i);
    chk("rst_mid_gnt", gnt_o, 1);
    @(posedge clk_i); #1;
    req_i = 0;
    @(posedge clk_i); #2;
    rst_ni = 0; req_i = 1;
    @(negedge clk_i);
    chk("rst_mid_gnt_follows", gnt_o, 1);
    chk("rst_mid_bready", master_b_ready, 0);
    @(posedge clk_i); #1;
    req_i = 0;
    @(posedge clk_i); #2;
    rst_ni = 1;
    k = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (rvalid_o) k++;
    end
    chk("rst_no_pulse", k, 0);

    r_data = 64'h0BAD_F00D_1234_5678;
    txn(0, 32'h8000, '0, '0, 3, "post_rst_rd");
    chk("post_rst_rdata", rdata_o, 64'h0BADF00D12345678);
    chk("post_rst_err", err_o, 0);

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_single_master.md
AXI_SINGLE_MASTER -- requirements
Module: axi_single_master

Interface
REQ-001 Parameters: AXI_ADDR_WIDTH, 32, address width; AXI_DATA_WIDTH, 64, data width; AXI_ID_WIDTH, 10, ID width; AXI_USER_WIDTH, 6, user width; AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, strobe width; MASTER_ID, 0, ID driven on AW/AR.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have these ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_i  in  1  core request
- we_i  in  1  1=write, 0=read
- addr_i  in  AXI_ADDR_WIDTH  byte address
- wdata_i  in  AXI_DATA_WIDTH  write data
- be_i  in  AXI_STRB_WIDTH  byte enables
- gnt_o  out  1  request accepted
- rvalid_o  out  1  completion pulse
- rdata_o  out  AXI_DATA_WIDTH  read data
- err_o  out  1  completion error, valid with rvalid_o
- master_aw_valid/ready  out/in  1/1  AW handshake
- master_aw_addr, master_aw_id, master_aw_user  out  ADDR/ID/USER  AW payload
- master_aw_len/size/burst  out  8/3/2  AW beat control
- master_aw_prot/region/lock/cache/qos  out  3/4/1/4/4  AW sideband
- master_w_valid/ready  out/in  1/1  W handshake
- master_w_data/strb/user/last  out  DATA/STRB/USER/1  W payload
- master_b_valid/ready  in/out  1/1  B handshake
- master_b_resp/id/user  in  2/ID/USER  B payload
- master_ar_*  same set as AW, read address channel
- master_r_valid/ready  in/out  1/1  R handshake
- master_r_data/resp/last/id/user  in  DATA/2/1/ID/USER  R payload

Function
REQ-004 The block SHALL issue exactly one single-beat AXI4 transaction per accepted request; at most one outstanding.
REQ-005 FSM states SHALL be IDLE, WRITE, WRESP, READ, RDATA.
REQ-006 In IDLE, gnt_o SHALL equal req_i combinationally; on req_i=1 the block SHALL register we_i, addr_i, wdata_i, be_i and move to WRITE (we_i=1) or READ (we_i=0).
REQ-007 gnt_o SHALL be 0 in all states other than IDLE.
REQ-008 In WRITE, aw_valid and w_valid SHALL both assert in the first WRITE cycle; each SHALL drop the cycle after its own handshake; FSM SHALL enter WRESP once both handshakes done (same or different cycles, either order).
REQ-009 In WRESP, b_ready SHALL be 1; on b_valid the FSM SHALL return to IDLE and pulse rvalid_o for one cycle, err_o=1 iff b_resp!=2'b00.
REQ-010 In READ, ar_valid SHALL be 1 until ar_ready, then FSM enters RDATA.
REQ-011 In RDATA, r_ready SHALL be 1; on r_valid the FSM SHALL latch r_data into rdata_o, pulse rvalid_o one cycle, err_o=1 iff r_resp!=2'b00, return to IDLE.
REQ-012 Valid signals SHALL never depend combinationally on the matching ready and SHALL not drop before handshake; payload SHALL be stable while valid.
REQ-013 Fixed fields: len=0, size=log2(AXI_STRB_WIDTH), burst=2'b01, lock=0, cache=4'b0000, prot=3'b000, region=0, qos=0, user=0, id=MASTER_ID, w_last=1.
REQ-014 rdata_o SHALL hold last read value until next read completion; on write completion rdata_o unchanged.
REQ-015 A new request SHALL be grantable in the cycle after rvalid_o (IDLE re-entry); minimum write latency req->rvalid_o = 3 cycles, read = 3 cycles, with zero-wait slave.
REQ-016 b_id/r_id/r_last/user inputs SHALL be ignored.

Reset
REQ-017 Reset SHALL force IDLE, all valid/ready outputs 0, gnt_o follows req_i, rvalid_o=0, err_o=0, rdata_o=0, regardless of state, including mid-transaction (transaction abandoned, no completion pulse).

Verification
REQ-018 Write, zero-wait slave: addr 0x1000, data 0xDEADBEEF_CAFEF00D, be 0xFF -> AW/W valid cycle 1, B accepted cycle 2, rvalid_o=1 err_o=0 at cycle 3, aw_size=3.
REQ-019 Write, aw_ready delayed 4 cycles, w_ready immediate -> w_valid drops after 1 cycle, aw_valid held with stable addr, WRESP entered only after AW handshake.
REQ-020 Read, r_data 0x0123_4567_89AB_CDEF, r_resp=2'b10 -> rdata_o=0x0123456789ABCDEF, err_o=1, rvalid_o one cycle.
REQ-021 req_i held high across back-to-back read then write -> gnt_o only in IDLE cycles, two distinct transactions, no overlap.
REQ-022 rst_ni low while in WRESP with b_valid pending -> all outputs at reset values, no rvalid_o pulse, next request completes normally.
